// File: rtl/apb_pkg.sv
// Shared definitions for the APB slave/master interfaces: FSM encoding,
// PPROT bit positions and width helpers.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  localparam int PPROT_PRIV_BIT  = 0;
  localparam int PPROT_NSEC_BIT  = 1;
  localparam int PPROT_INSTR_BIT = 2;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 32;
  localparam int DEF_TIMEOUT_CYCLE = 6;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int cnt_width(input int timeout_cycle);
    return $clog2(timeout_cycle + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Clear/enable wait counter; expired_o flags the enabled step on which the
// count reaches TIMEOUT_CYCLE.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLE = DEF_TIMEOUT_CYCLE,
  parameter int CNT_W         = cnt_width(TIMEOUT_CYCLE)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLE - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Flag the step itself so the owner can react on the same edge the count lands.
  assign expired_o = enable_i && !clear_i && (count_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_slave_if.sv
// APB slave terminating a bus segment and issuing one valid/ready request per
// transfer to a local block, with error and timeout reporting via PSLVERR.
module apb_slave_if
  import apb_pkg::*;
#(
  parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLE  = DEF_TIMEOUT_CYCLE
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  input  logic [APB_ADDR_WIDTH-1:0]   apb_addr_in,
  input  logic                        apb_psel_in,
  input  logic                        apb_penable_in,
  input  logic                        apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0]   apb_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] apb_strb_in,
  input  logic [2:0]                  apb_prot_in,
  output logic [APB_DATA_WIDTH-1:0]   apb_rdata_out,
  output logic                        apb_ready_out,
  output logic                        apb_slverr_out,
  output logic [APB_ADDR_WIDTH-1:0]   other_addr_out,
  output logic                        other_write_out,
  output logic [APB_DATA_WIDTH-1:0]   other_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] other_strb_out,
  output logic [2:0]                  other_prot_out,
  output logic                        other_valid_out,
  input  logic                        other_ready_in,
  input  logic [APB_DATA_WIDTH-1:0]   other_rdata_in,
  input  logic                        other_error_in
);

  localparam int STRB_W = strb_width(APB_DATA_WIDTH);

  apb_state_e                state_q,  state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic                      write_q,  write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [STRB_W-1:0]         strb_q,   strb_d;
  logic [2:0]                prot_q,   prot_d;
  logic                      valid_q,  valid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                      ready_q,  ready_d;
  logic                      slverr_q, slverr_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLE(TIMEOUT_CYCLE)
  ) u_wait_timer (
    .clk_i    (apb_clk_in),
    .rst_ni   (apb_rstn_in),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    ready_d   = ready_q;
    slverr_d  = slverr_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        if (apb_psel_in && !apb_penable_in) begin
          addr_d    = apb_addr_in;
          write_d   = apb_write_in;
          wdata_d   = apb_write_in ? apb_wdata_in : '0;
          strb_d    = apb_write_in ? apb_strb_in : '0;
          prot_d    = {apb_prot_in[PPROT_INSTR_BIT], apb_prot_in[PPROT_NSEC_BIT],
                       apb_prot_in[PPROT_PRIV_BIT]};
          valid_d   = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_REQ;
        end else if (apb_psel_in && apb_penable_in) begin
          // Enable phase with no setup: answer with an error, never touch the local side.
          rdata_d  = '0;
          slverr_d = 1'b1;
          ready_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_REQ: begin
        if (other_ready_in) begin
          valid_d  = 1'b0;
          rdata_d  = (write_q || other_error_in) ? '0 : other_rdata_in;
          slverr_d = other_error_in;
          ready_d  = apb_psel_in;
          state_d  = apb_psel_in ? ST_DONE : ST_IDLE;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            valid_d  = 1'b0;
            rdata_d  = '0;
            slverr_d = 1'b1;
            ready_d  = apb_psel_in;
            state_d  = apb_psel_in ? ST_DONE : ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        if (!apb_psel_in || apb_penable_in) begin
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prot_q   <= prot_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
    end
  end

  assign apb_rdata_out   = rdata_q;
  assign apb_ready_out   = ready_q;
  assign apb_slverr_out  = slverr_q;
  assign other_addr_out  = addr_q;
  assign other_write_out = write_q;
  assign other_wdata_out = wdata_q;
  assign other_strb_out  = strb_q;
  assign other_prot_out  = prot_q;
  assign other_valid_out = valid_q;

endmodule

// File: tb/tb_apb_slave_if.sv
// Directed bench for apb_slave_if: read, delayed write, timeout, local error,
// setup-less enable phase and asynchronous reset during a request.
module tb_apb_slave_if;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 6;

  logic            clk;
  logic            rstn;
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [2:0]      pprot;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;
  logic [AW-1:0]   o_addr;
  logic            o_write;
  logic [DW-1:0]   o_wdata;
  logic [DW/8-1:0] o_strb;
  logic [2:0]      o_prot;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_rdata;
  logic            o_error;

  int vectors;
  int miscompares;

  apb_slave_if #(
    .APB_DATA_WIDTH(DW),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLE (TO)
  ) dut (
    .apb_clk_in     (clk),
    .apb_rstn_in    (rstn),
    .apb_addr_in    (paddr),
    .apb_psel_in    (psel),
    .apb_penable_in (penable),
    .apb_write_in   (pwrite),
    .apb_wdata_in   (pwdata),
    .apb_strb_in    (pstrb),
    .apb_prot_in    (pprot),
    .apb_rdata_out  (prdata),
    .apb_ready_out  (pready),
    .apb_slverr_out (pslverr),
    .other_addr_out (o_addr),
    .other_write_out(o_write),
    .other_wdata_out(o_wdata),
    .other_strb_out (o_strb),
    .other_prot_out (o_prot),
    .other_valid_out(o_valid),
    .other_ready_in (o_ready),
    .other_rdata_in (o_rdata),
    .other_error_in (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                       input logic [DW/8-1:0] s, input logic [2:0] p);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = w;
    pwdata  = d;
    pstrb   = s;
    pprot   = p;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn    = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    o_ready = 1'b0;
    o_rdata = '0;
    o_error = 1'b0;

    #12;
    chk("rst_ready",  {63'd0, pready},  64'd0);
    chk("rst_slverr", {63'd0, pslverr}, 64'd0);
    chk("rst_valid",  {63'd0, o_valid}, 64'd0);
    chk("rst_rdata",  {32'd0, prdata},  64'd0);
    rstn = 1'b1;
    tick();

    // Read, local ready during the first request cycle.
    setup(32'h10, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b101);
    tick();
    chk("rd_valid_e0", {63'd0, o_valid}, 64'd1);
    chk("rd_strb0",    {60'd0, o_strb},  64'd0);
    chk("rd_wdata0",   {32'd0, o_wdata}, 64'd0);
    chk("rd_prot",     {61'd0, o_prot},  64'd5);
    chk("rd_ready_e0", {63'd0, pready},  64'd0);
    penable = 1'b1;
    o_ready = 1'b1;
    o_rdata = 32'hA5A5_0001;
    tick();
    o_ready = 1'b0;
    chk("rd_ready_e1", {63'd0, pready},  64'd1);
    chk("rd_rdata",    {32'd0, prdata},  64'hA5A5_0001);
    chk("rd_slverr",   {63'd0, pslverr}, 64'd0);
    chk("rd_valid_e1", {63'd0, o_valid}, 64'd0);
    tick();
    chk("rd_ready_e2", {63'd0, pready},  64'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    // Local side never answers: timeout after TO request cycles.
    setup(32'h80, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    penable = 1'b1;
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_valid_wait", {63'd0, o_valid}, 64'd1);
      chk("to_ready_wait", {63'd0, pready},  64'd0);
    end
    tick();
    chk("to_valid",  {63'd0, o_valid}, 64'd0);
    chk("to_ready",  {63'd0, pready},  64'd1);
    chk("to_slverr", {63'd0, pslverr}, 64'd1);
    chk("to_rdata",  {32'd0, prdata},  64'd0);
    tick();
    chk("to_ready_end",  {63'd0, pready},  64'd0);
    chk("to_slverr_end", {63'd0, pslverr}, 64'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    // Write, local ready delayed three cycles, then a back-to-back read.
    setup(32'h40, 1'b1, 32'h1234_5678, 4'hF, 3'b010);
    tick();
    chk("wr_addr",  {32'd0, o_addr},  64'h40);
    chk("wr_wdata", {32'd0, o_wdata}, 64'h1234_5678);
    chk("wr_strb",  {60'd0, o_strb},  64'hF);
    chk("wr_write", {63'd0, o_write}, 64'd1);
    penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_wait_ready", {63'd0, pready},  64'd0);
      chk("wr_wait_valid", {63'd0, o_valid}, 64'd1);
    end
    o_ready = 1'b1;
    o_rdata = 32'h7777_7777;
    tick();
    o_ready = 1'b0;
    chk("wr_ready",  {63'd0, pready},  64'd1);
    chk("wr_rdata",  {32'd0, prdata},  64'd0);
    chk("wr_slverr", {63'd0, pslverr}, 64'd0);
    tick();
    chk("wr_ready_end", {63'd0, pready}, 64'd0);
    setup(32'h44, 1'b0, 32'h0, 4'hF, 3'b000);
    tick();
    chk("b2b_valid", {63'd0, o_valid}, 64'd1);
    chk("b2b_addr",  {32'd0, o_addr},  64'h44);
    penable = 1'b1;
    o_ready = 1'b1;
    o_rdata = 32'h0000_BEEF;
    tick();
    o_ready = 1'b0;
    chk("b2b_rdata", {32'd0, prdata}, 64'h0000_BEEF);
    tick();

    // Read with local error: one-cycle PSLVERR, zero data.
    setup(32'h50, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    penable = 1'b1;
    o_ready = 1'b1;
    o_error = 1'b1;
    o_rdata = 32'hDEAD_BEEF;
    tick();
    o_ready = 1'b0;
    o_error = 1'b0;
    chk("err_ready",  {63'd0, pready},  64'd1);
    chk("err_slverr", {63'd0, pslverr}, 64'd1);
    chk("err_rdata",  {32'd0, prdata},  64'd0);
    tick();
    chk("err_slverr_end", {63'd0, pslverr}, 64'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    // Enable phase with no preceding setup phase.
    psel    = 1'b1;
    penable = 1'b1;
    tick();
    chk("nosu_valid",  {63'd0, o_valid}, 64'd0);
    chk("nosu_ready",  {63'd0, pready},  64'd1);
    chk("nosu_slverr", {63'd0, pslverr}, 64'd1);
    chk("nosu_addr",   {32'd0, o_addr},  64'h50);
    tick();
    chk("nosu_ready_end", {63'd0, pready},  64'd0);
    chk("nosu_valid_end", {63'd0, o_valid}, 64'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    // Asynchronous reset while a request is outstanding.
    setup(32'h100, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b111);
    tick();
    chk("ar_valid_pre", {63'd0, o_valid}, 64'd1);
    penable = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_valid", {63'd0, o_valid}, 64'd0);
    chk("ar_addr",  {32'd0, o_addr},  64'd0);
    chk("ar_wdata", {32'd0, o_wdata}, 64'd0);
    chk("ar_strb",  {60'd0, o_strb},  64'd0);
    chk("ar_write", {63'd0, o_write}, 64'd0);
    chk("ar_prot",  {61'd0, o_prot},  64'd0);
    chk("ar_ready", {63'd0, pready},  64'd0);
    psel    = 1'b0;
    penable = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    setup(32'h200, 1'b0, 32'h0, 4'h0, 3'b000);
    tick();
    chk("ar_rd_valid", {63'd0, o_valid}, 64'd1);
    penable = 1'b1;
    o_ready = 1'b1;
    o_rdata = 32'h5A5A_1234;
    tick();
    o_ready = 1'b0;
    chk("ar_rd_ready", {63'd0, pready},  64'd1);
    chk("ar_rd_rdata", {32'd0, prdata},  64'h5A5A_1234);
    chk("ar_rd_err",   {63'd0, pslverr}, 64'd0);
    tick();
    psel    = 1'b0;
    penable = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
